display_scan_ctrl: RTL

- Time-multiplexes NUM_DIGITS seven-segment digits onto one shared segment bus, one digit at a time.
- Divides the system clock into fixed scan slots and inserts a blanking interval at the start of each slot to prevent ghosting.
- Double-buffers the displayed value so that a whole refresh frame always shows one coherent value.
- Sits between the counter/BCD logic and the BCD-to-segment decoder plus the anode pins.

---
 rtl/display_pkg.sv | 21 ++
 rtl/scan_tick_gen.sv | 38 +++
 rtl/display_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg : shared constants and scan state type for the display scanner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  // Anodes are active-low, so the idle level is high.
  localparam logic ANODE_OFF     = 1'b1;
  localparam int   DEFAULT_DIG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// ----------------------------------------------------------------------------
// scan_tick_gen : modulo-SCAN_DIV slot counter with blank-end and slot-end flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scan_tick_gen #(
  parameter  int SCAN_DIV     = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int CNT_W        = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             slot_end,
  output logic             blank_end
);

  localparam logic [CNT_W-1:0] c_last       = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == c_last)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign slot_end  = (count == c_last);
  assign blank_end = (count == c_blank_last);

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl : multiplexed seven-segment scanner with per-slot blanking
//                     and frame-coherent double buffering of the digit value
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int DIG_W        = DEFAULT_DIG_W,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  logic [NUM_DIGITS*DIG_W-1:0] digits_in,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [DIG_W-1:0]            digit_code,
  output logic                        load_ack,
  output logic                        frame_done
);

  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cnt_w = $clog2(SCAN_DIV);
  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_an_off   = {NUM_DIGITS{ANODE_OFF}};

  scan_state_t                 r_state;
  logic [c_idx_w-1:0]          r_idx;
  logic [NUM_DIGITS*DIG_W-1:0] r_display;
  logic [NUM_DIGITS*DIG_W-1:0] r_pending;
  logic                        r_pending_valid;

  logic [c_cnt_w-1:0]    w_count;
  logic                  w_slot_end;
  logic                  w_blank_end;
  logic                  w_clr;
  logic                  w_frame_end;
  logic                  w_apply;
  logic [NUM_DIGITS-1:0] w_an_drive;
  logic [DIG_W-1:0]      w_digits [NUM_DIGITS];
  logic                  w_unused_count;

  assign w_clr = !en || (r_state == IDLE);

  scan_tick_gen #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .count     (w_count),
    .slot_end  (w_slot_end),
    .blank_end (w_blank_end)
  );

  // The slot position is fully described by the FSM phase and the two flags.
  assign w_unused_count = ^w_count;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign w_digits[g]   = r_display[g*DIG_W +: DIG_W];
      assign w_an_drive[g] = (r_idx == c_idx_w'(g)) ? ~ANODE_OFF : ANODE_OFF;
    end
  endgenerate

  assign w_frame_end = (r_state == DRIVE) && w_slot_end && (r_idx == c_last_idx);
  // The displayed value may only change where a new frame begins.
  assign w_apply     = en && ((r_state == IDLE) || w_frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_display       <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      an              <= c_an_off;
      digit_code      <= '0;
      load_ack        <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_done <= 1'b0;

      if (w_apply) begin
        if (load) begin
          r_display       <= digits_in;
          r_pending_valid <= 1'b0;
          load_ack        <= 1'b1;
        end else if (r_pending_valid) begin
          r_display       <= r_pending;
          r_pending_valid <= 1'b0;
          load_ack        <= 1'b1;
        end
      end else if (load) begin
        r_pending       <= digits_in;
        r_pending_valid <= 1'b1;
      end

      if (!en) begin
        r_state    <= IDLE;
        r_idx      <= '0;
        an         <= c_an_off;
        digit_code <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= BLANK;
            r_idx      <= '0;
            an         <= c_an_off;
            digit_code <= '0;
          end
          BLANK: begin
            if (w_blank_end) begin
              r_state    <= DRIVE;
              an         <= w_an_drive;
              digit_code <= w_digits[r_idx];
            end
          end
          DRIVE: begin
            if (w_slot_end) begin
              r_state    <= BLANK;
              an         <= c_an_off;
              digit_code <= '0;
              if (r_idx == c_last_idx) begin
                r_idx      <= '0;
                frame_done <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          default: begin
            r_state    <= IDLE;
            r_idx      <= '0;
            an         <= c_an_off;
            digit_code <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
